// File: rtl/glyph_plotter.sv
// Rasterizes one 8x16 monochrome glyph into framebuffer writes, raster order,
// with screen clipping, optional transparency and plot_ready back-pressure.
module glyph_plotter #(
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOUR_W    = 3,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int TRANSPARENT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [127:0]        pixels,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic [COLOUR_W-1:0] fg,
  input  logic [COLOUR_W-1:0] bg,
  input  logic                plot_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  // Handshake: a write completes on a cycle where plot && plot_ready; while
  // plot is high and plot_ready low, x/y/colour/plot are held unchanged.

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

  state_t                state, state_nxt;
  logic [6:0]            idx;
  logic [127:0]          glyph;
  logic [X_W-1:0]        ox;
  logic [Y_W-1:0]        oy;
  logic [COLOUR_W-1:0]   fg_r, bg_r;

  logic                  advance;
  logic [127:0]          src_glyph;
  logic [X_W-1:0]        src_ox;
  logic [Y_W-1:0]        src_oy;
  logic [COLOUR_W-1:0]   src_fg, src_bg;
  logic [6:0]            nidx;
  logic [X_W:0]          xs;
  logic [Y_W:0]          ys;
  logic                  bit_v;
  logic                  plot_nxt;

  assign advance = !plot || plot_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRAW;
      S_DRAW:  if (advance && idx == 7'd127) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // The pixel being loaded next: pixel 0 straight from the inputs on the
  // latch cycle, otherwise pixel idx+1 from the latched copies.
  always_comb begin
    src_glyph = (state == S_IDLE) ? pixels   : glyph;
    src_ox    = (state == S_IDLE) ? origin_x : ox;
    src_oy    = (state == S_IDLE) ? origin_y : oy;
    src_fg    = (state == S_IDLE) ? fg       : fg_r;
    src_bg    = (state == S_IDLE) ? bg       : bg_r;
    nidx      = (state == S_IDLE) ? 7'd0     : idx + 7'd1;
    xs        = {1'b0, src_ox} + {{(X_W-2){1'b0}}, nidx[2:0]};
    ys        = {1'b0, src_oy} + {{(Y_W-3){1'b0}}, nidx[6:3]};
    bit_v     = src_glyph[~nidx];
    plot_nxt  = (xs < SW) && (ys < SH) && (bit_v || (TRANSPARENT == 0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      glyph  <= '0;
      ox     <= '0;
      oy     <= '0;
      fg_r   <= '0;
      bg_r   <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            glyph  <= pixels;
            ox     <= origin_x;
            oy     <= origin_y;
            fg_r   <= fg;
            bg_r   <= bg;
            idx    <= 7'd0;
            x      <= xs[X_W-1:0];
            y      <= ys[Y_W-1:0];
            colour <= bit_v ? src_fg : src_bg;
            plot   <= plot_nxt;
          end
        end
        S_DRAW: begin
          if (advance) begin
            if (idx == 7'd127) begin
              plot <= 1'b0;
            end else begin
              idx    <= nidx;
              x      <= xs[X_W-1:0];
              y      <= ys[Y_W-1:0];
              colour <= bit_v ? src_fg : src_bg;
              plot   <= plot_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_plotter.sv
// Bench for glyph_plotter: an opaque and a transparent instance share stimulus;
// a raster-order write-list model per instance is checked every cycle.
module tb_glyph_plotter;

  logic         clock = 1'b0;
  logic         reset, start, plot_ready;
  logic [127:0] pixels;
  logic [8:0]   origin_x;
  logic [7:0]   origin_y;
  logic [2:0]   fg, bg;
  logic [8:0]   x0, x1;
  logic [7:0]   y0, y1;
  logic [2:0]   c0, c1;
  logic         plot0, plot1, busy0, busy1, done0, done1;

  glyph_plotter u_opaque (
    .clock(clock), .reset(reset), .start(start), .pixels(pixels),
    .origin_x(origin_x), .origin_y(origin_y), .fg(fg), .bg(bg),
    .plot_ready(plot_ready), .x(x0), .y(y0), .colour(c0),
    .plot(plot0), .busy(busy0), .done(done0)
  );

  glyph_plotter #(.TRANSPARENT(1)) u_transp (
    .clock(clock), .reset(reset), .start(start), .pixels(pixels),
    .origin_x(origin_x), .origin_y(origin_y), .fg(fg), .bg(bg),
    .plot_ready(plot_ready), .x(x1), .y(y1), .colour(c1),
    .plot(plot1), .busy(busy1), .done(done1)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard: expected writes {x, y, colour} in raster order
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  int  wr_cnt[2];
  int  done_cnt[2];
  int  done_cyc[2];
  int  max_x, max_y;
  int  ready_mode = 0;
  int  rk = 0;

  logic [19:0] prev_v[2];
  logic        prev_stall[2];
  logic        prev_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // plot_ready stimulus: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: plot_ready = 1'b1;
      1: begin plot_ready = ((rk % 4) == 0) || ((rk % 4) == 3); rk++; end
      default: plot_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // compare process
  always @(negedge clock) begin : monitor
    logic        p, bz, dn;
    logic [19:0] v, e;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        prev_stall[k] = 1'b0;
        prev_done[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        p  = (k == 0) ? plot0 : plot1;
        bz = (k == 0) ? busy0 : busy1;
        dn = (k == 0) ? done0 : done1;
        v  = (k == 0) ? {x0, y0, c0} : {x1, y1, c1};
        if (prev_stall[k]) check($sformatf("stall_hold%0d", k), {11'd0, p, v}, {11'd0, 1'b1, prev_v[k]});
        if (prev_done[k]) check($sformatf("busy_after_done%0d", k), {31'd0, bz}, 32'd0);
        if (dn) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          check($sformatf("busy_with_done%0d", k), {31'd0, bz}, 32'd1);
        end
        if (p && plot_ready) begin
          wr_cnt[k]++;
          if (k == 0) begin
            if (int'(v[19:11]) > max_x) max_x = int'(v[19:11]);
            if (int'(v[10:3]) > max_y) max_y = int'(v[10:3]);
          end
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            check($sformatf("unexpected_write%0d", k), {12'd0, v}, 32'hFFFFFFFF);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("write%0d", k), {12'd0, v}, {12'd0, e});
          end
        end
        prev_stall[k] = p && !plot_ready;
        prev_v[k]     = v;
        prev_done[k]  = dn;
      end
    end
  end

  // reference model: list every visible pixel of the cell in raster order
  task automatic build(input logic [127:0] g, input int ox, input int oy,
                       input logic [2:0] f, input logic [2:0] b);
    int xx, yy;
    logic bitv;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        bitv = g[127 - (r * 8 + c)];
        xx = ox + c;
        yy = oy + r;
        if (xx < 320 && yy < 240) begin
          exp_q0.push_back({xx[8:0], yy[7:0], bitv ? f : b});
          if (bitv) exp_q1.push_back({xx[8:0], yy[7:0], f});
        end
      end
    end
  endtask

  // driver: one glyph, waits for both done pulses; lat = cycles start->done
  task automatic run_glyph(input logic [127:0] g, input int ox, input int oy,
                           input logic [2:0] f, input logic [2:0] b,
                           input int mode, input bit dbl,
                           output int lat0, output int lat1);
    int s, n;
    build(g, ox, oy, f, b);
    for (int k = 0; k < 2; k++) begin wr_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0; end
    ready_mode = mode;
    rk = 0;
    @(posedge clock); #1;
    pixels = g; origin_x = ox[8:0]; origin_y = oy[7:0]; fg = f; bg = b;
    start = 1'b1;
    s = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    pixels = {$urandom, $urandom, $urandom, $urandom};
    origin_x = 9'($urandom_range(0, 511)); origin_y = 8'($urandom_range(0, 255));
    fg = 3'($urandom_range(0, 7)); bg = 3'($urandom_range(0, 7));
    n = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < 3000) begin
      @(posedge clock); #1;
      n++;
      start = dbl && ((cyc - s) == 5 || (cyc - s) == 60);
    end
    start = 1'b0;
    check("done_in_time", {31'd0, n < 3000}, 32'd1);
    repeat (4) @(posedge clock);
    #1;
    lat0 = done_cyc[0] - s;
    lat1 = done_cyc[1] - s;
    check("done_count0", done_cnt[0], 1);
    check("done_count1", done_cnt[1], 1);
    check("left_over0", exp_q0.size(), 0);
    check("left_over1", exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  logic [127:0] ones, two_px, g;
  int l0, l1, n;

  initial begin
    ones   = '1;
    two_px = {1'b1, 126'd0, 1'b1};
    reset = 1'b1; start = 1'b0; plot_ready = 1'b1;
    pixels = '0; origin_x = '0; origin_y = '0; fg = '0; bg = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state0", {8'd0, x0, y0, c0, plot0, busy0, done0}, 32'd0);
    check("reset_state1", {8'd0, x1, y1, c1, plot1, busy1, done1}, 32'd0);
    #2 reset = 1'b0;

    // pin the model with hand-worked values
    build(ones, 16, 32, 3'd7, 3'd0);
    check("model_cnt_ones", exp_q0.size(), 128);
    check("model_first_ones", {12'd0, exp_q0[0]}, {12'd0, 9'd16, 8'd32, 3'd7});
    check("model_last_ones", {12'd0, exp_q0[127]}, {12'd0, 9'd23, 8'd47, 3'd7});
    exp_q0.delete(); exp_q1.delete();
    build(two_px, 0, 0, 3'd2, 3'd0);
    check("model_cnt_transp", exp_q1.size(), 2);
    check("model_px0_transp", {12'd0, exp_q1[0]}, {12'd0, 9'd0, 8'd0, 3'd2});
    check("model_px1_transp", {12'd0, exp_q1[1]}, {12'd0, 9'd7, 8'd15, 3'd2});
    exp_q0.delete(); exp_q1.delete();
    build(ones, 316, 230, 3'd5, 3'd1);
    check("model_cnt_clip", exp_q0.size(), 40);
    exp_q0.delete(); exp_q1.delete();

    // all-ones, always ready
    run_glyph(ones, 16, 32, 3'd7, 3'd0, 0, 1'b0, l0, l1);
    check("latency_ones", l0, 129);
    check("writes_ones0", wr_cnt[0], 128);
    check("writes_ones1", wr_cnt[1], 128);

    // two corner pixels, transparent instance skips the rest
    run_glyph(two_px, 0, 0, 3'd2, 3'd0, 0, 1'b0, l0, l1);
    check("latency_transp", l1, 129);
    check("writes_transp", wr_cnt[1], 2);

    // 1,0,0,1 stall pattern
    run_glyph(ones, 40, 100, 3'd6, 3'd1, 1, 1'b0, l0, l1);
    check("writes_stall0", wr_cnt[0], 128);
    check("writes_stall1", wr_cnt[1], 128);

    // clipping at the bottom-right corner
    max_x = 0; max_y = 0;
    run_glyph(ones, 316, 230, 3'd5, 3'd1, 0, 1'b0, l0, l1);
    check("writes_clip", wr_cnt[0], 40);
    check("max_x_clip", max_x, 319);
    check("max_y_clip", max_y, 239);

    // asynchronous reset mid-glyph, then a fresh glyph
    g = {$urandom, $urandom, $urandom, $urandom};
    build(g, 50, 60, 3'd3, 3'd4);
    for (int k = 0; k < 2; k++) begin wr_cnt[k] = 0; done_cnt[k] = 0; end
    ready_mode = 0;
    @(posedge clock); #1;
    pixels = g; origin_x = 9'd50; origin_y = 8'd60; fg = 3'd3; bg = 3'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (wr_cnt[0] < 50 && n < 500) begin @(negedge clock); n++; end
    check("reach_pixel50", {31'd0, n < 500}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset0", {29'd0, plot0, busy0, done0}, 32'd0);
    check("async_reset1", {29'd0, plot1, busy1, done1}, 32'd0);
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    check("no_done_after_reset", done_cnt[0] + done_cnt[1], 0);
    run_glyph({$urandom, $urandom, $urandom, $urandom}, 8, 8, 3'd1, 3'd6, 2, 1'b0, l0, l1);

    // starts during a glyph are ignored
    run_glyph({$urandom, $urandom, $urandom, $urandom}, 100, 50, 3'd7, 3'd2, 0, 1'b1, l0, l1);
    check("latency_dbl_start", l0, 129);

    // randomized glyphs, origins (including clipping) and ready patterns
    for (int t = 0; t < 8; t++) begin
      run_glyph({$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 330), $urandom_range(0, 250),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 2), 1'b0, l0, l1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
